ulpi_reg_ctl: RTL

ULPI link-side controller sitting between ulpi_io (ULPI-side signals) and core logic. It sequences PHY register write and read transactions on the shared ULPI bus and yields to PHY-owned cycles (dir=1). It decodes RX CMD bytes into line state and event outputs. Requester interface is a single req/ack port; an optional post-reset init sequence configures the PHY before requests are served.

---
 rtl/ulpi_pkg.sv | 34 +++
 rtl/ulpi_rxcmd.sv | 44 ++++
 rtl/ulpi_reg_ctl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// ULPI link-side register controller: shared constants and state encoding.
// ULPI_REG_CTL_INIT_EN adds the post-reset PHY init state.
package ulpi_pkg;

    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
    localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;

    localparam int         RXCMD_LS_LSB  = 0;
    localparam int         RXCMD_EV_LSB  = 4;
    localparam logic [1:0] RXCMD_EV_ACT  = 2'b01;

    typedef enum logic [3:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        WR_STP,
        RD_CMD,
        RD_TURN,
        RD_DATA,
        DONE
`ifdef ULPI_REG_CTL_INIT_EN
        , INIT
`endif
    } ctl_state_t;

    function automatic logic [7:0] txcmd(input logic [1:0] pfx,
                                         input logic [5:0] addr);
        return {pfx, addr};
    endfunction

endpackage

// File: rtl/ulpi_rxcmd.sv
// ULPI bus-direction tracking and RX CMD capture.
// Read data cycles are excluded so register reads never look like RX CMDs.
module ulpi_rxcmd
    import ulpi_pkg::*;
(
    input  logic       ulpi_clk,
    input  logic       ulpi_rst_n,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_in,
    input  logic       rd_data_cycle,
    output logic       dir_q,
    output logic       turnaround,
    output logic       bus_free,
    output logic [7:0] rx_cmd,
    output logic       rx_cmd_stb,
    output logic [1:0] line_state,
    output logic       rx_active
);

    logic capture;

    assign turnaround = ulpi_dir != dir_q;
    assign bus_free   = !ulpi_dir && !dir_q;
    assign capture    = ulpi_dir && dir_q && !ulpi_nxt && !rd_data_cycle;

    always_ff @(posedge ulpi_clk) begin
        if (!ulpi_rst_n) begin
            dir_q      <= 1'b0;
            rx_cmd     <= 8'h00;
            rx_cmd_stb <= 1'b0;
        end else begin
            dir_q      <= ulpi_dir;
            rx_cmd_stb <= capture;
            if (capture) begin
                rx_cmd <= ulpi_data_in;
            end
        end
    end

    assign line_state = rx_cmd[RXCMD_LS_LSB +: 2];
    assign rx_active  = rx_cmd[RXCMD_EV_LSB +: 2] == RXCMD_EV_ACT;

endmodule

// File: rtl/ulpi_reg_ctl.sv
// ULPI PHY register read/write sequencer with PHY-preempt retry and timeout.
// ULPI_REG_CTL_INIT_EN enables the post-reset Function/OTG Control init writes.
module ulpi_reg_ctl
    import ulpi_pkg::*;
#(
    parameter int         TIMEOUT        = 255,
    parameter logic [7:0] INIT_FUNC_CTRL = 8'h45,
    parameter logic [7:0] INIT_OTG_CTRL  = 8'h00
) (
    input  logic       ulpi_clk,
    input  logic       ulpi_rst_n,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    input  logic       reg_req,
    input  logic       reg_we,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       reg_ack,
    output logic       reg_err,
    output logic [7:0] reg_rdata,
    output logic [7:0] rx_cmd,
    output logic       rx_cmd_stb,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       init_done
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

`ifdef ULPI_REG_CTL_INIT_EN
    localparam ctl_state_t ST_RST = INIT;
`else
    localparam ctl_state_t ST_RST = IDLE;
`endif

    ctl_state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       err_q, err_n;
    logic       load_user, load_init;
    logic       counting, timed_out;
    logic       dir_q, turnaround, bus_free;
    logic       init_step;

    ulpi_rxcmd u_rxcmd (
        .ulpi_clk      (ulpi_clk),
        .ulpi_rst_n    (ulpi_rst_n),
        .ulpi_dir      (ulpi_dir),
        .ulpi_nxt      (ulpi_nxt),
        .ulpi_data_in  (ulpi_data_in),
        .rd_data_cycle (state == RD_DATA),
        .dir_q         (dir_q),
        .turnaround    (turnaround),
        .bus_free      (bus_free),
        .rx_cmd        (rx_cmd),
        .rx_cmd_stb    (rx_cmd_stb),
        .line_state    (line_state),
        .rx_active     (rx_active)
    );

    // Waiting for the PHY to release the bus is not a timeout condition.
    assign counting = ((state == WR_CMD || state == RD_CMD) && bus_free)
                    || state == WR_DATA || state == RD_TURN;
    assign timed_out = cnt == CNT_LAST;
    assign cnt_n     = (state_n == state && counting) ? cnt + 8'd1 : 8'd0;

    always_comb begin
        state_n       = state;
        err_n         = err_q;
        load_user     = 1'b0;
        load_init     = 1'b0;
        ulpi_stp      = 1'b0;
        ulpi_data_out = 8'h00;
        unique case (state)
            IDLE: begin
                if (reg_req && init_done && bus_free) begin
                    state_n   = reg_we ? WR_CMD : RD_CMD;
                    load_user = 1'b1;
                    err_n     = 1'b0;
                end
            end
            WR_CMD: begin
                if (bus_free) begin
                    ulpi_data_out = txcmd(TXCMD_REGW, addr_q);
                    if (ulpi_nxt) begin
                        state_n = WR_DATA;
                    end else if (timed_out) begin
                        state_n = WR_STP;
                        err_n   = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                if (ulpi_dir) begin
                    state_n = WR_CMD;
                end else begin
                    ulpi_data_out = wdata_q;
                    if (ulpi_nxt) begin
                        state_n = WR_STP;
                    end else if (timed_out) begin
                        state_n = WR_STP;
                        err_n   = 1'b1;
                    end
                end
            end
            WR_STP: begin
                ulpi_stp = 1'b1;
                state_n  = DONE;
            end
            RD_CMD: begin
                if (bus_free) begin
                    ulpi_data_out = txcmd(TXCMD_REGR, addr_q);
                    if (ulpi_nxt) begin
                        state_n = RD_TURN;
                    end else if (timed_out) begin
                        state_n = WR_STP;
                        err_n   = 1'b1;
                    end
                end
            end
            RD_TURN: begin
                if (turnaround && ulpi_dir) begin
                    state_n = ulpi_nxt ? DONE : RD_DATA;
                    err_n   = ulpi_nxt;
                end else if (timed_out) begin
                    state_n = WR_STP;
                    err_n   = 1'b1;
                end
            end
            RD_DATA: begin
                state_n = DONE;
                if (!(ulpi_dir && dir_q)) begin
                    err_n = 1'b1;
                end
            end
            DONE: begin
`ifdef ULPI_REG_CTL_INIT_EN
                if (init_done || (!err_q && init_step)) begin
                    state_n = IDLE;
                end else begin
                    state_n = INIT;
                end
`else
                state_n = IDLE;
`endif
            end
`ifdef ULPI_REG_CTL_INIT_EN
            INIT: begin
                if (bus_free) begin
                    state_n   = WR_CMD;
                    load_init = 1'b1;
                    err_n     = 1'b0;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ulpi_clk) begin
        if (!ulpi_rst_n) begin
            state   <= ST_RST;
            cnt     <= 8'd0;
            err_q   <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= err_n;
            if (load_user) begin
                addr_q  <= reg_addr;
                wdata_q <= reg_wdata;
            end else if (load_init) begin
                addr_q  <= init_step ? ADDR_OTG_CTRL : ADDR_FUNC_CTRL;
                wdata_q <= init_step ? INIT_OTG_CTRL : INIT_FUNC_CTRL;
            end
            if (state == RD_DATA && ulpi_dir && dir_q) begin
                rdata_q <= ulpi_data_in;
            end
        end
    end

`ifdef ULPI_REG_CTL_INIT_EN
    logic init_done_q;

    always_ff @(posedge ulpi_clk) begin
        if (!ulpi_rst_n) begin
            init_step   <= 1'b0;
            init_done_q <= 1'b0;
        end else if (state == DONE && !init_done_q && !err_q) begin
            if (init_step) begin
                init_done_q <= 1'b1;
            end else begin
                init_step <= 1'b1;
            end
        end
    end

    assign init_done = init_done_q;
`else
    assign init_step = 1'b0;
    assign init_done = 1'b1;
`endif

    // Init-sequence writes complete silently.
    assign reg_ack   = state == DONE && init_done;
    assign reg_err   = reg_ack && err_q;
    assign reg_rdata = rdata_q;

endmodule
